// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory loader. Accepts a framed byte
//                stream (0xA5, 16-bit big-endian word count, payload, optional
//                XOR checksum), assembles big-endian words and writes them
//                from address 0 into the spare imem write port. Holds the
//                core in reset until the image is complete; parks in an
//                error state on a framing or checksum failure.
//  Config      : IMEM_LOADER_CSUM_EN - when defined the frame ends with a
//                checksum byte (XOR of payload bytes) that is verified before
//                release; when undefined the frame has no checksum and a
//                one-cycle FLUSH state precedes DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 24,
   parameter int DEPTH  = 4096,
   parameter int BPW    = (DATA_W + 7) / 8
) (
   input  logic              iw_clk,
   input  logic              iw_rst_n,
   input  logic [7:0]        iw_byte,
   input  logic              iw_byte_valid,
   output logic              or_byte_ready,
   input  logic              iw_restart,
   output logic              or_mem_we,
   output logic [ADDR_W-1:0] or_mem_addr,
   output logic [DATA_W-1:0] or_mem_wdata,
   output logic              or_core_rst,
   output logic              or_done,
   output logic              or_err
);

   localparam logic [7:0]        C_MAGIC     = 8'hA5;
   localparam int                C_BCW       = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [C_BCW-1:0]  C_LAST_BYTE = C_BCW'(BPW - 1);
   localparam logic [16:0]       C_DEPTH     = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_SYNC   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CSUM   = 3'd4,
      S_FLUSH  = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   // State entered once the payload (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CSUM_EN
   localparam state_t C_TAIL = S_CSUM;
`else
   localparam state_t C_TAIL = S_FLUSH;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_words_left;
   logic [15:0]       w_len;
   logic [C_BCW-1:0]  r_byte_cnt;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [ADDR_W-1:0] r_wcnt;
   logic              w_take;
   logic              w_word_done;
   logic              w_restart;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]        r_xor;
`endif

   // Next-state logic plus handshake / word-assembly decode.
   always_comb begin
      w_take      = iw_byte_valid & or_byte_ready;
      // Shift the new byte in; bits beyond DATA_W fall off the top, which
      // discards the unused high bits of each word's first byte.
      w_acc_nxt   = DATA_W'({r_acc, iw_byte});
      w_len       = {r_len_hi, iw_byte};
      w_word_done = w_take && (r_state == S_DATA) && (r_byte_cnt == C_LAST_BYTE);
      w_restart   = iw_restart && ((r_state == S_DONE) || (r_state == S_ERR));
      w_state_nxt = r_state;
      case (r_state)
         S_SYNC: begin
            if (w_take && (iw_byte == C_MAGIC)) w_state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (w_take) w_state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (w_take) begin
               if ({1'b0, w_len} > C_DEPTH) w_state_nxt = S_ERR;
               else if (w_len == 16'd0)     w_state_nxt = C_TAIL;
               else                         w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_word_done && (r_words_left == 16'd1)) w_state_nxt = C_TAIL;
         end
         S_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
            if (w_take) w_state_nxt = (iw_byte == r_xor) ? S_DONE : S_ERR;
`else
            w_state_nxt = S_SYNC;
`endif
         end
         S_FLUSH: begin
            w_state_nxt = S_DONE;
         end
         S_DONE, S_ERR: begin
            if (iw_restart) w_state_nxt = S_SYNC;
         end
         default: begin
            w_state_nxt = S_SYNC;
         end
      endcase
   end

   // State register.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) r_state <= S_SYNC;
      else           r_state <= w_state_nxt;
   end

   // Registered status outputs, decoded from the state being entered.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         or_byte_ready <= 1'b0;
         or_core_rst   <= 1'b1;
         or_done       <= 1'b0;
         or_err        <= 1'b0;
      end else begin
         or_byte_ready <= (w_state_nxt != S_FLUSH) && (w_state_nxt != S_DONE) &&
                          (w_state_nxt != S_ERR);
         or_core_rst   <= (w_state_nxt != S_DONE);
         or_done       <= (w_state_nxt == S_DONE);
         or_err        <= (w_state_nxt == S_ERR);
      end
   end

   // Imem write port: one-cycle strobe on the edge taking a word's last byte.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         or_mem_we    <= 1'b0;
         or_mem_addr  <= '0;
         or_mem_wdata <= '0;
      end else begin
         or_mem_we <= w_word_done;
         if (w_word_done) begin
            or_mem_addr  <= r_wcnt;
            or_mem_wdata <= w_acc_nxt;
         end
      end
   end

   // Length capture, word assembly and word/byte counters.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         r_len_hi     <= '0;
         r_words_left <= '0;
         r_byte_cnt   <= '0;
         r_acc        <= '0;
         r_wcnt       <= '0;
      end else begin
         if (w_take && (r_state == S_LEN_HI)) r_len_hi <= iw_byte;
         if (w_take && (r_state == S_LEN_LO)) r_words_left <= w_len;
         if (w_take && (r_state == S_DATA)) begin
            r_acc      <= w_acc_nxt;
            r_byte_cnt <= w_word_done ? '0 : r_byte_cnt + C_BCW'(1);
         end
         if (w_word_done) begin
            r_wcnt       <= r_wcnt + ADDR_W'(1);
            r_words_left <= r_words_left - 16'd1;
         end
         if (w_restart) begin
            r_wcnt     <= '0;
            r_byte_cnt <= '0;
         end
      end
   end

`ifdef IMEM_LOADER_CSUM_EN
   // Running XOR of payload bytes, cleared on reload.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n)                         r_xor <= '0;
      else if (w_restart)                    r_xor <= '0;
      else if (w_take && (r_state == S_DATA)) r_xor <= r_xor ^ iw_byte;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader (default
//                parameters). Frames carry a checksum byte only when
//                IMEM_LOADER_CSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        restart = 1'b0;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [23:0] mem_wdata;
   logic        core_rst;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   // write log filled by the monitor only
   int          cyc = 0;
   int          n_wr = 0;
   logic [23:0] wr_addr [64];
   logic [23:0] wr_data [64];
   int          wr_cyc  [64];
   int          fall_cyc = -1;
   logic        prev_core_rst = 1'b1;

   imem_loader dut (
      .iw_clk        (clk),
      .iw_rst_n      (rst_n),
      .iw_byte       (byte_in),
      .iw_byte_valid (byte_valid),
      .or_byte_ready (byte_ready),
      .iw_restart    (restart),
      .or_mem_we     (mem_we),
      .or_mem_addr   (mem_addr),
      .or_mem_wdata  (mem_wdata),
      .or_core_rst   (core_rst),
      .or_done       (done),
      .or_err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we && (n_wr < 64)) begin
         wr_addr[n_wr] <= mem_addr;
         wr_data[n_wr] <= mem_wdata;
         wr_cyc[n_wr]  <= cyc;
         n_wr          <= n_wr + 1;
      end
      if (prev_core_rst && !core_rst) fall_cyc <= cyc;
      prev_core_rst <= core_rst;
   end

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         byte_in    = b;
         byte_valid = 1'b1;
         acc        = byte_ready;
         @(posedge clk);
      end
      if (!acc) begin
         errors++; checks++;
         $display("FAIL send_byte: byte %02h never accepted (ready=0), required ready=1", b);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOADER_CSUM_EN
      send_byte(b);
`else
      if (b == 8'hxx) idle();  // no checksum byte in this build
`endif
   endtask

   task automatic wait_end(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done || err) break;
      end
      @(negedge clk);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
      checks++;
      if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      checks++;
      if (mem_wdata !== 24'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      checks++;
      if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++;
      rst_n = 1'b1;
      #1;
      if (byte_ready !== 1'b0) begin errors++; $display("FAIL ready_pre_edge: got %b want 0", byte_ready); end
      checks++;
      @(posedge clk); #1;
      if (byte_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b want 1", byte_ready); end
      checks++;
   endtask

   task automatic test_good_frame();
      int base;
      base = n_wr;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
      send_csum(8'h77);  // 11^22^33^44^55^66
      idle();
      wait_end(10);
      if (n_wr - base !== 2) begin errors++; $display("FAIL good_nwr: got %0d want 2", n_wr - base); end
      checks++;
      if (wr_addr[base] !== 24'd0 || wr_data[base] !== 24'h112233) begin
         errors++; $display("FAIL good_w0: got addr=%h data=%h want addr=0 data=112233", wr_addr[base], wr_data[base]);
      end
      checks++;
      if (wr_addr[base+1] !== 24'd1 || wr_data[base+1] !== 24'h445566) begin
         errors++; $display("FAIL good_w1: got addr=%h data=%h want addr=1 data=445566", wr_addr[base+1], wr_data[base+1]);
      end
      checks++;
      if (wr_cyc[base+1] - wr_cyc[base] !== 3) begin
         errors++; $display("FAIL good_spacing: got %0d want 3", wr_cyc[base+1] - wr_cyc[base]);
      end
      checks++;
      if (fall_cyc < wr_cyc[base+1] + 1) begin
         errors++; $display("FAIL good_rst_fall: got cycle %0d want >= %0d", fall_cyc, wr_cyc[base+1] + 1);
      end
      checks++;
      if (done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL good_status: got done=%b core_rst=%b err=%b want 1 0 0", done, core_rst, err);
      end
      checks++;
      if (byte_ready !== 1'b0) begin errors++; $display("FAIL good_ready: got %b want 0", byte_ready); end
      checks++;
   endtask

   task automatic test_restart();
      int base;
      do_restart();
      if (core_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
         errors++; $display("FAIL restart_status: got core_rst=%b done=%b ready=%b want 1 0 1", core_rst, done, byte_ready);
      end
      checks++;
      base = n_wr;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
      send_csum(8'h89);  // AB^CD^EF
      idle();
      wait_end(10);
      if (n_wr - base !== 1 || wr_addr[base] !== 24'd0 || wr_data[base] !== 24'hABCDEF) begin
         errors++; $display("FAIL restart_write: got n=%0d addr=%h data=%h want 1 0 abcdef", n_wr - base, wr_addr[base], wr_data[base]);
      end
      checks++;
      if (done !== 1'b1 || core_rst !== 1'b0) begin
         errors++; $display("FAIL restart_done: got done=%b core_rst=%b want 1 0", done, core_rst);
      end
      checks++;
   endtask

`ifdef IMEM_LOADER_CSUM_EN
   task automatic test_bad_csum();
      int base;
      do_restart();
      base = n_wr;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
      send_byte(8'h01);
      idle();
      wait_end(10);
      if (n_wr - base !== 2) begin errors++; $display("FAIL badcs_nwr: got %0d want 2", n_wr - base); end
      checks++;
      if (err !== 1'b1 || core_rst !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL badcs_status: got err=%b core_rst=%b ready=%b done=%b want 1 1 0 0", err, core_rst, byte_ready, done);
      end
      checks++;
   endtask
`endif

   task automatic test_garbage();
      int base;
      do_restart();
      base = n_wr;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      send_csum(8'h00);
      idle();
      wait_end(10);
      if (n_wr - base !== 0) begin errors++; $display("FAIL garbage_nwr: got %0d want 0", n_wr - base); end
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0) begin
         errors++; $display("FAIL garbage_done: got done=%b err=%b core_rst=%b want 1 0 0", done, err, core_rst);
      end
      checks++;
   endtask

   task automatic test_len_err();
      int base;
      do_restart();
      base = n_wr;
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
      idle();
      @(negedge clk);
      if (err !== 1'b1 || core_rst !== 1'b1 || byte_ready !== 1'b0) begin
         errors++; $display("FAIL lenerr_status: got err=%b core_rst=%b ready=%b want 1 1 0", err, core_rst, byte_ready);
      end
      checks++;
      repeat (3) @(negedge clk);
      if (n_wr - base !== 0) begin errors++; $display("FAIL lenerr_nwr: got %0d want 0", n_wr - base); end
      checks++;
   endtask

   task automatic test_bubbles();
      int base;
      logic [7:0] pay [6];
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_restart();
      base = n_wr;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      for (int i = 0; i < 6; i++) begin
         send_byte(pay[i]);
         idle();
      end
      send_csum(8'h77);
      idle();
      wait_end(10);
      if (n_wr - base !== 2) begin errors++; $display("FAIL bubble_nwr: got %0d want 2", n_wr - base); end
      checks++;
      if (wr_data[base] !== 24'h112233 || wr_data[base+1] !== 24'h445566 || wr_addr[base+1] !== 24'd1) begin
         errors++; $display("FAIL bubble_data: got %h %h addr1=%h want 112233 445566 1", wr_data[base], wr_data[base+1], wr_addr[base+1]);
      end
      checks++;
      if (wr_cyc[base+1] - wr_cyc[base] !== 6) begin
         errors++; $display("FAIL bubble_spacing: got %0d want 6", wr_cyc[base+1] - wr_cyc[base]);
      end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL bubble_done: got %b want 1", done); end
      checks++;
   endtask

   task automatic test_reset_mid();
      int base;
      do_restart();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      #1;
      if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_strobe: got %b want 1", mem_we); end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if (mem_we !== 1'b0 || mem_addr !== 24'h0 || mem_wdata !== 24'h0) begin
         errors++; $display("FAIL mid_wport: got we=%b addr=%h data=%h want 0 0 0", mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if (core_rst !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL mid_status: got core_rst=%b ready=%b done=%b err=%b want 1 0 0 0", core_rst, byte_ready, done, err);
      end
      checks++;
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = n_wr;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      send_csum(8'h70);  // 12^34^56
      idle();
      wait_end(10);
      if (n_wr - base !== 1 || wr_addr[base] !== 24'd0 || wr_data[base] !== 24'h123456) begin
         errors++; $display("FAIL mid_reload: got n=%0d addr=%h data=%h want 1 0 123456", n_wr - base, wr_addr[base], wr_data[base]);
      end
      checks++;
      if (done !== 1'b1 || core_rst !== 1'b0) begin
         errors++; $display("FAIL mid_done: got done=%b core_rst=%b want 1 0", done, core_rst);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_restart();
`ifdef IMEM_LOADER_CSUM_EN
      test_bad_csum();
`endif
      test_garbage();
      test_len_err();
      test_bubbles();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
